// File: rtl/sram_uart_dump.sv
// sram_uart_dump: streams a range of 16-bit SRAM words out of UART TX as
// 8N1 bytes, high byte first. Words are fetched through the SRAM controller
// one at a time; the read latency is absorbed in S_READ/S_READ_WAIT.
// Optional feature macro: DUMP_HEADER_EN -- when defined, the 15-byte PPM
// header "P6\n320 240\n255\n" is sent before the first word.
module sram_uart_dump #(
  parameter int CLKS_PER_BIT      = 434,
  parameter int SRAM_READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  localparam logic [9:0] BIT_LAST = 10'(CLKS_PER_BIT - 1);
  localparam logic [7:0] RD_LAST  = 8'(SRAM_READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef DUMP_HEADER_EN
    S_HEADER,
`endif
    S_READ,
    S_READ_WAIT,
    S_TX_HIGH,
    S_TX_LOW,
    S_DONE
  } state_t;

  state_t      state;
  logic [17:0] addr;
  logic [17:0] count;
  logic [15:0] word;
  logic [7:0]  wait_cnt;
  logic [9:0]  clk_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  tx_shift;
  logic        tx_run;
  logic        bit_tick;
  logic        byte_end;

`ifdef DUMP_HEADER_EN
  logic [3:0]  hdr_idx;

  function automatic logic [7:0] hdr_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    hdr_rom = 8'h50;  // 'P'
      4'd1:    hdr_rom = 8'h36;  // '6'
      4'd2:    hdr_rom = 8'h0A;
      4'd3:    hdr_rom = 8'h33;  // '3'
      4'd4:    hdr_rom = 8'h32;  // '2'
      4'd5:    hdr_rom = 8'h30;  // '0'
      4'd6:    hdr_rom = 8'h20;  // ' '
      4'd7:    hdr_rom = 8'h32;  // '2'
      4'd8:    hdr_rom = 8'h34;  // '4'
      4'd9:    hdr_rom = 8'h30;  // '0'
      4'd10:   hdr_rom = 8'h0A;
      4'd11:   hdr_rom = 8'h32;  // '2'
      4'd12:   hdr_rom = 8'h35;  // '5'
      4'd13:   hdr_rom = 8'h35;  // '5'
      default: hdr_rom = 8'h0A;
    endcase
  endfunction
`endif

  // The controller is only ever read.
  assign SRAM_we_n = 1'b1;

  // Bit-period and byte-end strobes of the serializer.
  always_comb begin
    bit_tick = tx_run && (clk_cnt == BIT_LAST);
    byte_end = bit_tick && (bit_cnt == 4'd9);
  end

  // Control FSM with the byte serializer folded in; a byte load later in the
  // block overrides the generic bit advance so consecutive bytes abut.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= S_IDLE;
      addr         <= '0;
      count        <= '0;
      word         <= '0;
      wait_cnt     <= '0;
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      tx_shift     <= '0;
      tx_run       <= 1'b0;
      SRAM_address <= '0;
      UART_TX_O    <= 1'b1;
      Busy         <= 1'b0;
      Done         <= 1'b0;
`ifdef DUMP_HEADER_EN
      hdr_idx      <= '0;
`endif
    end else begin
      Done <= 1'b0;

      // Bit advance: bit_cnt 0 = start, 1..8 = data LSB first, 9 = stop.
      if (tx_run) begin
        if (bit_tick) begin
          clk_cnt <= '0;
          if (bit_cnt != 4'd9) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd8) begin
              UART_TX_O <= 1'b1;
            end else begin
              UART_TX_O <= tx_shift[0];
              tx_shift  <= {1'b0, tx_shift[7:1]};
            end
          end
        end else begin
          clk_cnt <= clk_cnt + 10'd1;
        end
      end

      case (state)
        S_IDLE: begin
          if (Start) begin
            addr  <= Start_address;
            count <= Word_count;
`ifdef DUMP_HEADER_EN
            Busy      <= 1'b1;
            hdr_idx   <= '0;
            tx_shift  <= hdr_rom(4'd0);
            UART_TX_O <= 1'b0;
            bit_cnt   <= '0;
            clk_cnt   <= '0;
            tx_run    <= 1'b1;
            state     <= S_HEADER;
`else
            if (Word_count == 18'd0) begin
              Done  <= 1'b1;
              state <= S_DONE;
            end else begin
              Busy         <= 1'b1;
              SRAM_address <= Start_address;
              state        <= S_READ;
            end
`endif
          end
        end

`ifdef DUMP_HEADER_EN
        S_HEADER: begin
          if (byte_end) begin
            if (hdr_idx == 4'd14) begin
              tx_run <= 1'b0;
              if (count == 18'd0) begin
                Done  <= 1'b1;
                Busy  <= 1'b0;
                state <= S_DONE;
              end else begin
                SRAM_address <= addr;
                state        <= S_READ;
              end
            end else begin
              hdr_idx   <= hdr_idx + 4'd1;
              tx_shift  <= hdr_rom(hdr_idx + 4'd1);
              UART_TX_O <= 1'b0;
              bit_cnt   <= '0;
              clk_cnt   <= '0;
            end
          end
        end
`endif

        // Address was registered on entry; this cycle counts toward latency.
        S_READ: begin
          wait_cnt <= 8'd1;
          state    <= S_READ_WAIT;
        end

        S_READ_WAIT: begin
          if (wait_cnt == RD_LAST) begin
            word  <= SRAM_read_data;
            state <= S_TX_HIGH;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_TX_HIGH: begin
          if (!tx_run) begin
            tx_shift  <= word[15:8];
            UART_TX_O <= 1'b0;
            bit_cnt   <= '0;
            clk_cnt   <= '0;
            tx_run    <= 1'b1;
          end else if (byte_end) begin
            tx_shift  <= word[7:0];
            UART_TX_O <= 1'b0;
            bit_cnt   <= '0;
            clk_cnt   <= '0;
            state     <= S_TX_LOW;
          end
        end

        S_TX_LOW: begin
          if (byte_end) begin
            tx_run <= 1'b0;
            count  <= count - 18'd1;
            addr   <= addr + 18'd1;
            if (count != 18'd1) begin
              SRAM_address <= addr + 18'd1;
              state        <= S_READ;
            end else begin
              Done  <= 1'b1;
              Busy  <= 1'b0;
              state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_uart_dump.sv
// Directed bench for sram_uart_dump with CLKS_PER_BIT = 4, latency 2.
module tb_sram_uart_dump;

  localparam int CPB = 4;
  localparam int LAT = 2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [17:0] Start_address = '0;
  logic [17:0] Word_count = '0;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  sram_uart_dump #(.CLKS_PER_BIT(CPB), .SRAM_READ_LATENCY(LAT)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .Start_address(Start_address), .Word_count(Word_count),
    .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n),
    .SRAM_read_data(SRAM_read_data), .UART_TX_O(UART_TX_O),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  // SRAM model: data for an address appears LAT cycles after it is presented.
  logic [15:0] mem [0:262143];
  logic [15:0] rd_p1, rd_p2;
  always @(posedge Clock) begin
    rd_p1 <= mem[SRAM_address];
    rd_p2 <= rd_p1;
  end
  assign SRAM_read_data = rd_p2;

  int cyc = 0;
  always @(posedge Clock) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // UART receiver and Done monitor, sampling on the falling edge.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic [9:0] rx_bits;
  int         rx_pos = 0;
  int         rx_start = 0;
  bit         rx_active = 0;
  bit         rx_bad = 0;
  int         frame_err = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         busy_at_done = 0;
  bit         tx_low_seen = 0;

  always @(negedge Clock) begin
    if (Done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      if (Busy) busy_at_done = busy_at_done + 1;
    end
    if (UART_TX_O == 1'b0) tx_low_seen = 1;
    if (Reset) begin
      rx_active = 0;
    end else if (!rx_active) begin
      if (UART_TX_O == 1'b0) begin
        rx_active = 1;
        rx_start  = cyc;
        rx_bits   = '0;
        rx_bad    = 0;
        rx_pos    = 1;
      end
    end else begin
      if (rx_pos % CPB == 0) rx_bits[rx_pos / CPB] = UART_TX_O;
      else if (rx_bits[rx_pos / CPB] !== UART_TX_O) rx_bad = 1;
      rx_pos = rx_pos + 1;
      if (rx_pos == 10 * CPB) begin
        rx_active = 0;
        if (rx_bits[0] != 1'b0 || rx_bits[9] != 1'b1 || rx_bad) frame_err = frame_err + 1;
        rx_q.push_back(rx_bits[8:1]);
        rx_t.push_back(rx_start);
      end
    end
  end

  int c0 = 0;
  int done_base = 0;

  task automatic clear_mon();
    rx_q.delete();
    rx_t.delete();
    tx_low_seen = 0;
  endtask

  task automatic do_start(input logic [17:0] a, input logic [17:0] n);
    @(negedge Clock);
    done_base     = done_cnt;
    Start         = 1'b1;
    Start_address = a;
    Word_count    = n;
    @(negedge Clock);
    Start = 1'b0;
    c0    = cyc;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt == done_base && n < limit) begin
      @(negedge Clock);
      n++;
    end
    if (done_cnt == done_base) chk("done_timeout", 32'd0, 32'd1);
    repeat (6) @(negedge Clock);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] e [4];
    e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
    chk({tag, "_nbytes"}, rx_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < rx_q.size()) chk($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, e[i]});
  endtask

  task automatic check_timing(input string tag);
    int exp_t [4];
    exp_t[0] = 2 + LAT;
    exp_t[1] = 2 + LAT + 10 * CPB;
    exp_t[2] = 2 * (2 + LAT) + 20 * CPB;
    exp_t[3] = 2 * (2 + LAT) + 30 * CPB;
    for (int i = 0; i < 4; i++)
      if (i < rx_t.size()) chk($sformatf("%s_start%0d", tag, i), rx_t[i] - c0, exp_t[i]);
    chk({tag, "_done_at"}, done_cyc - c0, 2 * (20 * CPB + 2 + LAT));
    chk({tag, "_done_pulses"}, done_cnt - done_base, 32'd1);
  endtask

`ifdef DUMP_HEADER_EN
  logic [7:0] hdr_exp [17];
`endif

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
    mem[18'h00010] = 16'h1234;
    mem[18'h00011] = 16'hABCD;
    mem[18'h3FFFF] = 16'h5AC3;
    mem[18'h00000] = 16'h0F1E;
    mem[18'h00020] = 16'h00FF;

    repeat (3) @(negedge Clock);
    chk("rst_addr", SRAM_address, 18'h0);
    chk("rst_we_n", SRAM_we_n, 1'b1);
    chk("rst_tx", UART_TX_O, 1'b1);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);

`ifdef DUMP_HEADER_EN
    hdr_exp = '{8'h50, 8'h36, 8'h0A, 8'h33, 8'h32, 8'h30, 8'h20, 8'h32, 8'h34,
                8'h30, 8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A, 8'h00, 8'hFF};
    clear_mon();
    do_start(18'h00020, 18'd1);
    wait_done(2000);
    chk("hdr_nbytes", rx_q.size(), 32'd17);
    for (int i = 0; i < 17; i++)
      if (i < rx_q.size()) chk($sformatf("hdr_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, hdr_exp[i]});
    if (rx_t.size() > 0) chk("hdr_first_start", rx_t[0] - c0, 32'd0);
    chk("hdr_done_at", done_cyc - c0, 17 * 10 * CPB + 2 + LAT);
    chk("hdr_done_pulses", done_cnt - done_base, 32'd1);
`else
    // Basic two-word dump.
    clear_mon();
    do_start(18'h00010, 18'd2);
    chk("t1_busy", Busy, 1'b1);
    wait_done(1000);
    check_bytes("t1", 8'h12, 8'h34, 8'hAB, 8'hCD);
    check_timing("t1");
    chk("t1_busy_after", Busy, 1'b0);
    chk("t1_we_n", SRAM_we_n, 1'b1);

    // Zero-length request.
    clear_mon();
    do_start(18'h00030, 18'd0);
    chk("t2_done_now", Done, 1'b1);
    repeat (20) @(negedge Clock);
    chk("t2_done_at", done_cyc - c0, 32'd0);
    chk("t2_done_pulses", done_cnt - done_base, 32'd1);
    chk("t2_tx_low", tx_low_seen, 1'b0);
    chk("t2_nbytes", rx_q.size(), 32'd0);
    chk("t2_addr", SRAM_address, 18'h00011);

    // Address wrap at the top of SRAM.
    clear_mon();
    do_start(18'h3FFFF, 18'd2);
    wait_done(1000);
    check_bytes("t3", 8'h5A, 8'hC3, 8'h0F, 8'h1E);
    chk("t3_addr", SRAM_address, 18'h00000);

    // Second Start during the first word's low byte is ignored.
    clear_mon();
    do_start(18'h00010, 18'd2);
    while (cyc < c0 + 60) @(negedge Clock);
    Start = 1'b1;
    Start_address = 18'h3FFFF;
    Word_count = 18'd1;
    @(negedge Clock);
    Start = 1'b0;
    wait_done(1000);
    check_bytes("t4", 8'h12, 8'h34, 8'hAB, 8'hCD);
    check_timing("t4");

    // Reset in the middle of the second byte, then a clean rerun.
    clear_mon();
    do_start(18'h00010, 18'd2);
    while (cyc < c0 + 50) @(negedge Clock);
    chk("t5_tx_before", UART_TX_O, 1'b0);
    #1 Reset = 1'b1;
    #1;
    chk("t5_tx_rst", UART_TX_O, 1'b1);
    chk("t5_busy_rst", Busy, 1'b0);
    chk("t5_done_rst", Done, 1'b0);
    chk("t5_addr_rst", SRAM_address, 18'h0);
    repeat (2) @(negedge Clock);
    #1 Reset = 1'b0;
    repeat (3) @(negedge Clock);
    clear_mon();
    do_start(18'h00010, 18'd2);
    wait_done(1000);
    check_bytes("t5", 8'h12, 8'h34, 8'hAB, 8'hCD);
    check_timing("t5");
`endif

    chk("frame_errors", frame_err, 32'd0);
    chk("busy_at_done", busy_at_done, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
